// File: rtl/pll_clk_sequencer.sv
// Arbitrated PLL reconfiguration sequencer: grants hk or cpu, parks the core clock on
// the external clock, reprograms the PLL, waits for lock, then releases the bypass.
module pll_clk_sequencer #(
  parameter int TRIM_W        = 26,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_CYCLES   = 256
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              hk_req,
  input  logic              hk_ena,
  input  logic [TRIM_W-1:0] hk_trim,
  input  logic [4:0]        hk_div,
  input  logic [2:0]        hk_sel,
  output logic              hk_ack,
  input  logic              cpu_req,
  input  logic              cpu_ena,
  input  logic [TRIM_W-1:0] cpu_trim,
  input  logic [4:0]        cpu_div,
  input  logic [2:0]        cpu_sel,
  output logic              cpu_ack,
  output logic              pll_ena,
  output logic [TRIM_W-1:0] pll_trim,
  output logic [4:0]        pll_div,
  output logic [2:0]        pll_sel,
  output logic              pll_bypass,
  output logic              busy,
  output logic              owner
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > LOCK_CYCLES) ? SETTLE_CYCLES : LOCK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT  = 3'd1,
    BYPASS = 3'd2,
    LOAD   = 3'd3,
    LOCK   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                prio_r, prio_s;
  logic                win_s;
  logic                lat_ena_r, lat_ena_s;
  logic [TRIM_W-1:0]   lat_trim_r, lat_trim_s;
  logic [4:0]          lat_div_r, lat_div_s;
  logic [2:0]          lat_sel_r, lat_sel_s;
  logic                hk_ack_s, cpu_ack_s;
  logic                pll_ena_s, pll_bypass_s;
  logic [TRIM_W-1:0]   pll_trim_s;
  logic [4:0]          pll_div_s;
  logic [2:0]          pll_sel_s;
  logic                busy_s, owner_s;

  // State, counter, latched config and all registered outputs.
  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      prio_r     <= 1'b0;
      lat_ena_r  <= 1'b0;
      lat_trim_r <= '0;
      lat_div_r  <= 5'd0;
      lat_sel_r  <= 3'd0;
      hk_ack     <= 1'b0;
      cpu_ack    <= 1'b0;
      pll_ena    <= 1'b0;
      pll_trim   <= '0;
      pll_div    <= 5'd0;
      pll_sel    <= 3'd0;
      pll_bypass <= 1'b1;
      busy       <= 1'b0;
      owner      <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      prio_r     <= prio_s;
      lat_ena_r  <= lat_ena_s;
      lat_trim_r <= lat_trim_s;
      lat_div_r  <= lat_div_s;
      lat_sel_r  <= lat_sel_s;
      hk_ack     <= hk_ack_s;
      cpu_ack    <= cpu_ack_s;
      pll_ena    <= pll_ena_s;
      pll_trim   <= pll_trim_s;
      pll_div    <= pll_div_s;
      pll_sel    <= pll_sel_s;
      pll_bypass <= pll_bypass_s;
      busy       <= busy_s;
      owner      <= owner_s;
    end
  end

  // Next state plus the output values that belong to the state being entered.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    prio_s       = prio_r;
    win_s        = 1'b0;
    lat_ena_s    = lat_ena_r;
    lat_trim_s   = lat_trim_r;
    lat_div_s    = lat_div_r;
    lat_sel_s    = lat_sel_r;
    hk_ack_s     = 1'b0;
    cpu_ack_s    = 1'b0;
    pll_ena_s    = pll_ena;
    pll_trim_s   = pll_trim;
    pll_div_s    = pll_div;
    pll_sel_s    = pll_sel;
    pll_bypass_s = pll_bypass;
    busy_s       = busy;
    owner_s      = owner;

    case (state_r)
      IDLE: begin
        // prio_r names the requester favoured on a tie; a lone requester always wins
        if (hk_req && cpu_req) begin
          win_s = prio_r;
        end else begin
          win_s = cpu_req;
        end
        if (hk_req || cpu_req) begin
          state_s = GRANT;
          busy_s  = 1'b1;
          owner_s = win_s;
          prio_s  = ~win_s;
          if (win_s) begin
            lat_ena_s  = cpu_ena;
            lat_trim_s = cpu_trim;
            lat_div_s  = cpu_div;
            lat_sel_s  = cpu_sel;
          end else begin
            lat_ena_s  = hk_ena;
            lat_trim_s = hk_trim;
            lat_div_s  = hk_div;
            lat_sel_s  = hk_sel;
          end
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        state_s      = BYPASS;
        cnt_s        = '0;
        pll_bypass_s = 1'b1;
      end
      BYPASS: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s    = LOAD;
          pll_ena_s  = 1'b0;
          pll_trim_s = lat_trim_r;
          pll_div_s  = lat_div_r;
          pll_sel_s  = lat_sel_r;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      LOAD: begin
        if (lat_ena_r) begin
          state_s   = LOCK;
          cnt_s     = '0;
          pll_ena_s = 1'b1;
        end else begin
          state_s   = DONE;
          hk_ack_s  = ~owner;
          cpu_ack_s = owner;
        end
      end
      LOCK: begin
        if (cnt_r == LOCK_LAST) begin
          state_s      = DONE;
          hk_ack_s     = ~owner;
          cpu_ack_s    = owner;
          pll_bypass_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// Self-checking bench: a cycle-timeline model of each granted transaction is compared
// against the DUT every cycle, plus directed literal checks of the documented timing.
module tb_pll_clk_sequencer;

  localparam int TW = 26;
  localparam int S  = 16;
  localparam int L  = 256;

  logic          clock, resetb;
  logic          hk_req, hk_ena, hk_ack;
  logic [TW-1:0] hk_trim;
  logic [4:0]    hk_div;
  logic [2:0]    hk_sel;
  logic          cpu_req, cpu_ena, cpu_ack;
  logic [TW-1:0] cpu_trim;
  logic [4:0]    cpu_div;
  logic [2:0]    cpu_sel;
  logic          pll_ena, pll_bypass, busy, owner;
  logic [TW-1:0] pll_trim;
  logic [4:0]    pll_div;
  logic [2:0]    pll_sel;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit done_r = 1'b0;

  pll_clk_sequencer #(.TRIM_W(TW), .SETTLE_CYCLES(S), .LOCK_CYCLES(L)) dut (
    .clock(clock), .resetb(resetb),
    .hk_req(hk_req), .hk_ena(hk_ena), .hk_trim(hk_trim), .hk_div(hk_div), .hk_sel(hk_sel),
    .hk_ack(hk_ack),
    .cpu_req(cpu_req), .cpu_ena(cpu_ena), .cpu_trim(cpu_trim), .cpu_div(cpu_div),
    .cpu_sel(cpu_sel), .cpu_ack(cpu_ack),
    .pll_ena(pll_ena), .pll_trim(pll_trim), .pll_div(pll_div), .pll_sel(pll_sel),
    .pll_bypass(pll_bypass), .busy(busy), .owner(owner)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic report();
    if (!done_r) begin
      done_r = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    end
  endtask

  // Cycle counter and requester behaviour: req drops on the edge that samples ack.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      if (hk_ack === 1'b1) hk_req = 1'b0;
      if (cpu_ack === 1'b1) cpu_req = 1'b0;
    end
  end

  // ---------------- transaction-timeline reference model ----------------
  bit            m_valid = 1'b0;
  bit            m_active, m_prio, m_win, m_cena;
  int            m_k;
  logic [TW-1:0] m_ctrim;
  logic [4:0]    m_cdiv;
  logic [2:0]    m_csel;
  logic          e_ena, e_bypass, e_hk_ack, e_cpu_ack, e_busy, e_owner;
  logic [TW-1:0] e_trim;
  logic [4:0]    e_div;
  logic [2:0]    e_sel;

  initial begin
    forever begin
      @(negedge clock);
      if (m_valid) begin
        check("pll_ena",    32'(pll_ena),    32'(e_ena));
        check("pll_bypass", 32'(pll_bypass), 32'(e_bypass));
        check("pll_trim",   32'(pll_trim),   32'(e_trim));
        check("pll_div",    32'(pll_div),    32'(e_div));
        check("pll_sel",    32'(pll_sel),    32'(e_sel));
        check("hk_ack",     32'(hk_ack),     32'(e_hk_ack));
        check("cpu_ack",    32'(cpu_ack),    32'(e_cpu_ack));
        check("busy",       32'(busy),       32'(e_busy));
        check("owner",      32'(owner),      32'(e_owner));
      end
      // Expectations for the next cycle, from the inputs the DUT samples at the next edge
      if (resetb === 1'b0) begin
        m_valid = 1'b1; m_active = 1'b0; m_prio = 1'b0;
        e_ena = 1'b0; e_bypass = 1'b1; e_trim = '0; e_div = 5'd0; e_sel = 3'd0;
        e_hk_ack = 1'b0; e_cpu_ack = 1'b0; e_busy = 1'b0; e_owner = 1'b0;
      end else if (m_valid) begin
        e_hk_ack  = 1'b0;
        e_cpu_ack = 1'b0;
        if (!m_active) begin
          if (hk_req || cpu_req) begin
            m_win    = (hk_req && cpu_req) ? m_prio : cpu_req;
            m_prio   = !m_win;
            m_cena   = m_win ? cpu_ena  : hk_ena;
            m_ctrim  = m_win ? cpu_trim : hk_trim;
            m_cdiv   = m_win ? cpu_div  : hk_div;
            m_csel   = m_win ? cpu_sel  : hk_sel;
            m_active = 1'b1;
            m_k      = 1;
            e_busy   = 1'b1;
            e_owner  = m_win;
          end
        end else begin
          int dur;
          m_k++;
          dur = m_cena ? (S + L + 3) : (S + 3);
          if (m_k > dur) begin
            m_active = 1'b0;
            e_busy   = 1'b0;
          end else begin
            if (m_k == 2) e_bypass = 1'b1;
            if (m_k == S + 2) begin
              e_ena = 1'b0; e_trim = m_ctrim; e_div = m_cdiv; e_sel = m_csel;
            end
            if (m_cena && m_k == S + 3) e_ena = 1'b1;
            if (m_k == dur) begin
              e_hk_ack  = !m_win;
              e_cpu_ack = m_win;
              if (m_cena) e_bypass = 1'b0;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_cycle(input int n);
    do @(negedge clock); while (cyc < n);
  endtask

  task automatic wait_ack(input bit who, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if ((who && cpu_ack === 1'b1) || (!who && hk_ack === 1'b1)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check(who ? "cpu_ack_timeout" : "hk_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_hk(input logic e, input logic [TW-1:0] t, input logic [4:0] d, input logic [2:0] s);
    hk_ena = e; hk_trim = t; hk_div = d; hk_sel = s;
  endtask

  task automatic set_cpu(input logic e, input logic [TW-1:0] t, input logic [4:0] d, input logic [2:0] s);
    cpu_ena = e; cpu_trim = t; cpu_div = d; cpu_sel = s;
  endtask

  task automatic do_reset();
    tick();
    resetb = 1'b0; hk_req = 1'b0; cpu_req = 1'b0;
    tick();
    tick();
    resetb = 1'b1;
  endtask

  initial begin
    #200000;
    check("watchdog", 32'd0, 32'd1);
    report();
    $finish;
  end

  initial begin
    int t0, ta, tb;
    resetb = 1'b0; hk_req = 1'b0; cpu_req = 1'b0;
    set_hk(1'b0, 26'd0, 5'd0, 3'd0);
    set_cpu(1'b0, 26'd0, 5'd0, 3'd0);
    tick();
    tick();
    resetb = 1'b1;
    @(negedge clock);
    check("rst_pll_ena", 32'(pll_ena), 32'd0);
    check("rst_bypass",  32'(pll_bypass), 32'd1);
    check("rst_trim",    32'(pll_trim), 32'd0);
    check("rst_div",     32'(pll_div), 32'd0);
    check("rst_sel",     32'(pll_sel), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_acks",    32'({hk_ack, cpu_ack}), 32'd0);

    // hk, ena=1: full lock sequence
    set_hk(1'b1, 26'h3FFFFFF, 5'd8, 3'd1);
    tick(); hk_req = 1'b1; t0 = cyc;
    at_cycle(t0 + 2);
    check("t2_bypass", 32'(pll_bypass), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    at_cycle(t0 + 18);
    check("t18_trim", 32'(pll_trim), 32'h3FFFFFF);
    check("t18_div", 32'(pll_div), 32'd8);
    check("t18_ena", 32'(pll_ena), 32'd0);
    at_cycle(t0 + 19);
    check("t19_ena", 32'(pll_ena), 32'd1);
    wait_ack(1'b0, 400, ta);
    check("hk_lat_275", 32'(ta - t0), 32'd275);
    check("hk_done_bypass", 32'(pll_bypass), 32'd0);
    at_cycle(ta + 1);
    check("hk_idle_busy", 32'(busy), 32'd0);

    // cpu, ena=0: bypass stays, short sequence
    set_cpu(1'b0, 26'h0000123, 5'd3, 3'd2);
    tick(); cpu_req = 1'b1; t0 = cyc;
    wait_ack(1'b1, 100, ta);
    check("cpu_lat_19", 32'(ta - t0), 32'd19);
    check("cpu_owner", 32'(owner), 32'd1);
    check("cpu_bypass", 32'(pll_bypass), 32'd1);
    check("cpu_pll_ena", 32'(pll_ena), 32'd0);
    check("cpu_div", 32'(pll_div), 32'd3);

    // simultaneous requests after reset: hk, cpu, then hk again
    do_reset();
    set_hk(1'b0, 26'h0AAAAAA, 5'd4, 3'd4);
    set_cpu(1'b0, 26'h1555555, 5'd9, 3'd5);
    tick(); hk_req = 1'b1; cpu_req = 1'b1; t0 = cyc;
    wait_ack(1'b0, 100, ta);
    check("rr1_hk_lat", 32'(ta - t0), 32'd19);
    check("rr1_owner", 32'(owner), 32'd0);
    at_cycle(ta + 1);
    check("rr_gap_busy", 32'(busy), 32'd0);
    at_cycle(ta + 2);
    check("rr2_grant_busy", 32'(busy), 32'd1);
    check("rr2_owner", 32'(owner), 32'd1);
    wait_ack(1'b1, 100, tb);
    check("rr2_cpu_gap", 32'(tb - ta), 32'd20);
    check("rr2_div", 32'(pll_div), 32'd9);
    tick(); hk_req = 1'b1; cpu_req = 1'b1; t0 = cyc;
    wait_ack(1'b0, 100, ta);
    check("rr3_hk_lat", 32'(ta - t0), 32'd19);
    check("rr3_div", 32'(pll_div), 32'd4);
    wait_ack(1'b1, 100, tb);
    check("rr4_cpu_gap", 32'(tb - ta), 32'd20);

    // cpu request arriving mid hk sequence waits its turn
    set_hk(1'b1, 26'h2345678, 5'd5, 3'd3);
    set_cpu(1'b1, 26'h0ABCDEF, 5'd20, 3'd6);
    tick(); hk_req = 1'b1; t0 = cyc;
    at_cycle(t0 + 49);
    tick(); cpu_req = 1'b1;
    wait_ack(1'b0, 400, ta);
    check("mid_hk_lat", 32'(ta - t0), 32'd275);
    check("mid_hk_div", 32'(pll_div), 32'd5);
    wait_ack(1'b1, 400, tb);
    check("mid_cpu_gap", 32'(tb - ta), 32'd276);
    check("mid_cpu_trim", 32'(pll_trim), 32'h0ABCDEF);
    check("mid_cpu_div", 32'(pll_div), 32'd20);
    check("mid_cpu_sel", 32'(pll_sel), 32'd6);

    // reset at cycle 100 of a lock sequence, then a clean rerun
    set_hk(1'b1, 26'h1234567, 5'd7, 3'd2);
    tick(); hk_req = 1'b1; t0 = cyc;
    at_cycle(t0 + 99);
    tick(); resetb = 1'b0; hk_req = 1'b0;
    tick(); resetb = 1'b1;
    @(negedge clock);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ena", 32'(pll_ena), 32'd0);
    check("mrst_bypass", 32'(pll_bypass), 32'd1);
    check("mrst_trim", 32'(pll_trim), 32'd0);
    at_cycle(cyc + 30);
    tick(); hk_req = 1'b1; t0 = cyc;
    wait_ack(1'b0, 400, ta);
    check("post_rst_lat", 32'(ta - t0), 32'd275);
    check("post_rst_trim", 32'(pll_trim), 32'h1234567);

    tick();
    tick();
    report();
    $finish;
  end

endmodule
